serial_mouse_encoder: RTL and testbench
=======================================

# serial_mouse_encoder

Converts relative mouse motion and button state into the Microsoft serial-mouse byte stream (identification byte plus 3-byte packets). It sits directly upstream of the 8250 UART receive path and replaces the physical RX byte source. It drives the UART's receive-data/receive-strobe inputs and consumes the UART's "byte taken" pulse. Motion is accumulated between packets, so no movement is lost while the host is slow.

## Interface
- `BYTE_GAP`, default 8333: minimum clocks between the `iTaken` of one byte and `oValid` of the next (models serial byte time).
- `ACC_W`, default 10: width of the signed motion accumulators.
- `iClk`  in  1  system clock; all logic on rising edge.
- `iRstN`  in  1  reset. Asynchronous assert, active-low.
- `iMove`  in  1  one-cycle strobe; `iDx`/`iDy` valid.
- `iDx`  in  9  signed X delta; positive = right.
- `iDy`  in  9  signed Y delta; positive = down.
- `iBtnL`  in  1  left button level.
- `iBtnR`  in  1  right button level.
- `iIdent`  in  1  one-cycle request to send identification (host RTS rising edge).
- `oData`  out  8  byte presented to the UART.
- `oValid`  out  1  `oData` valid; held until taken.
- `iTaken`  in  1  one-cycle pulse: UART consumed `oData`.

## Operation
- **Accumulators `accX`/`accY`** (`ACC_W` signed):
  - On `iMove`, add the sign-extended delta.
  - Saturate at -2^(ACC_W-1) and 2^(ACC_W-1)-1; never wrap.
- **Packet latch**: `pX = clamp(accX, -128, 127)`, same for `pY`.
  - In the same cycle, `accX <= accX - pX + (iMove ? iDx : 0)`, and likewise for Y. The residual is kept and concurrent motion is never dropped.
  - L and R are sampled into `pL`/`pR` and `lastBtn` at latch.
- **Packet bytes**:
  - B1 = `{1'b0, 1'b1, pL, pR, pY[7:6], pX[7:6]}`
  - B2 = `{2'b00, pX[5:0]}`
  - B3 = `{2'b00, pY[5:0]}`
- **States**: IDLE, IDENT, B1, B2, B3, GAP.
  - **IDLE**: if `accX != 0`, `accY != 0`, or `{iBtnL, iBtnR} != lastBtn`, latch and go to B1.
  - **B1/B2/B3**: `oData` = the byte, `oValid` = 1. On `iTaken`: B1 goes to B2, B2 goes to B3, B3 goes to GAP.
  - **GAP**: `oValid` = 0, counter counts `BYTE_GAP-1` down to 0, then returns to the state recorded as next. That is B2/B3 inside a packet, or IDLE after B3 or IDENT. The gap is inserted after every taken byte, including B1 and B2. The exact flow is Bn → GAP → Bn+1.
  - **IDENT**: `oData` = 0x4D, `oValid` = 1. On `iTaken`, go to GAP and then IDLE.
- **`iIdent`**: from any state, next state is IDENT. It also clears the accumulators, `lastBtn`, and the gap counter, and aborts any partial packet. The remainder is not resent.
  - `iIdent` has priority over `iMove` and over `iTaken` in the same cycle. That `iTaken` is ignored.
- `iTaken` while `oValid` = 0 is ignored.
- `iMove` during B1..GAP only accumulates; it never alters a latched packet.

## Timing
- **Reset values**:
  - `oValid` = 0, `oData` = 0x00, state = IDLE.
  - `accX`/`accY` = 0, `lastBtn` = 00, gap counter = 0.
- **Latency**:
  - `iMove` at cycle N: accumulator updated at N+1. IDLE sees the nonzero accumulator and latches at N+1, so B1 `oValid` = 1 at N+2.
  - Button change with the block idle: `oValid` = 1 two cycles after the change.
  - `iIdent` at N: IDENT with `oValid` = 1 at N+1.
- **Handshake**:
  - `oValid` and `oData` are stable until the cycle after `iTaken`.
  - `oValid` falls in the cycle after `iTaken` (GAP entered).
  - The next `oValid` rises exactly `BYTE_GAP` cycles after the `iTaken` cycle.
- **Packet throughput**: 3 bytes per packet. Back-to-back packets are possible when motion stays nonzero.
- **Mid-operation reset**: `iRstN` low forces all reset values immediately; there is no partial-packet resume.

## Test plan
- Reset, then `iMove` with dx = +5, dy = -3, buttons 00, UART taking every byte → bytes 0x4C, 0x05, 0x3D, each `oValid` ≥ `BYTE_GAP` apart. Accumulators are 0 afterwards.
- `iMove` dx = +300, dy = 0 → first packet X = +127 (0x41, 0x3F, 0x00), second X = +127, third X = +46. No motion is lost.
- `iIdent` pulse while B2 is being presented → the cycle after shows `oData` = 0x4D with `oValid` = 1. After it is taken, no B2/B3 is emitted and the accumulators are 0.
- `iBtnL` rises with no motion → packet 0x60, 0x00, 0x00. A second packet follows when `iBtnL` falls: 0x40, 0x00, 0x00.
- Hold `iTaken` low for 1000 cycles during B1 → `oValid`/`oData` stay constant. Concurrent `iMove` dx = +2 appears in the next packet, not the current one.
- Assert `iRstN` low mid-GAP → `oValid` drops at once, the state is IDLE, and no further bytes appear until new input.

Source files
------------

// File: rtl/serial_mouse_encoder.sv
// Microsoft serial-mouse byte source: accumulates relative motion and buttons and
// presents identification / 3-byte packets to the UART receive path, one byte per handshake.
module serial_mouse_encoder #(
    parameter int unsigned BYTE_GAP = 8333,
    parameter int unsigned ACC_W    = 10
) (
    input  logic              iClk,
    input  logic              iRstN,
    input  logic              iMove,
    input  logic signed [8:0] iDx,
    input  logic signed [8:0] iDy,
    input  logic              iBtnL,
    input  logic              iBtnR,
    input  logic              iIdent,
    output logic [7:0]        oData,
    output logic              oValid,
    input  logic              iTaken
);
    localparam int unsigned EW    = ACC_W + 2;
    localparam int unsigned CNT_W = (BYTE_GAP > 1) ? $clog2(BYTE_GAP) : 1;
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(BYTE_GAP - 1);
    localparam logic signed [ACC_W-1:0] CMAX = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] CMIN = ACC_W'(-128);

    typedef enum logic [2:0] {S_IDLE, S_IDENT, S_B1, S_B2, S_B3, S_GAP} state_t;

    state_t                  state_q, state_d, next_q, next_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] accx_q, accx_d, accy_q, accy_d;
    logic signed [7:0]       px_q, px_d, py_q, py_d;
    logic                    pl_q, pl_d, pr_q, pr_d;
    logic [1:0]              btn_q, last_q, last_d;

    logic                    latch;
    logic signed [7:0]       cx, cy;
    logic signed [EW-1:0]    mvx, mvy, subx, suby;

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [EW-1:0] v);
        logic signed [EW-1:0] hi, lo;
        hi = {3'b000, {(ACC_W-1){1'b1}}};
        lo = {3'b111, {(ACC_W-1){1'b0}}};
        if (v > hi) return hi[ACC_W-1:0];
        if (v < lo) return lo[ACC_W-1:0];
        return v[ACC_W-1:0];
    endfunction

    function automatic logic signed [7:0] clamp8(input logic signed [ACC_W-1:0] v);
        if (v > CMAX) return 8'h7F;
        if (v < CMIN) return 8'h80;
        return v[7:0];
    endfunction

    function automatic logic signed [EW-1:0] sx_acc(input logic signed [ACC_W-1:0] v);
        return {{2{v[ACC_W-1]}}, v};
    endfunction

    function automatic logic signed [EW-1:0] sx9(input logic signed [8:0] v);
        return {{(EW-9){v[8]}}, v};
    endfunction

    function automatic logic signed [EW-1:0] sx8(input logic signed [7:0] v);
        return {{(EW-8){v[7]}}, v};
    endfunction

    always_comb begin
        state_d = state_q;
        next_d  = next_q;
        cnt_d   = cnt_q;
        px_d    = px_q;
        py_d    = py_q;
        pl_d    = pl_q;
        pr_d    = pr_q;
        last_d  = last_q;
        oValid  = 1'b0;
        oData   = '0;

        // Latch subtracts the clamped packet value and adds concurrent motion in one step,
        // so the residual and any same-cycle delta both survive.
        cx     = clamp8(accx_q);
        cy     = clamp8(accy_q);
        latch  = (state_q == S_IDLE) && ((accx_q != '0) || (accy_q != '0) || (btn_q != last_q));
        mvx    = iMove ? sx9(iDx) : '0;
        mvy    = iMove ? sx9(iDy) : '0;
        subx   = latch ? sx8(cx) : '0;
        suby   = latch ? sx8(cy) : '0;
        accx_d = sat_acc(sx_acc(accx_q) - subx + mvx);
        accy_d = sat_acc(sx_acc(accy_q) - suby + mvy);

        case (state_q)
            S_IDLE: begin
                if (latch) begin
                    px_d    = cx;
                    py_d    = cy;
                    pl_d    = btn_q[1];
                    pr_d    = btn_q[0];
                    last_d  = btn_q;
                    state_d = S_B1;
                end
            end
            S_IDENT: begin
                oValid = 1'b1;
                oData  = 8'h4D;
                if (iTaken) begin
                    state_d = S_GAP;
                    next_d  = S_IDLE;
                    cnt_d   = GAP_LOAD;
                end
            end
            S_B1: begin
                oValid = 1'b1;
                oData  = {2'b01, pl_q, pr_q, py_q[7:6], px_q[7:6]};
                if (iTaken) begin
                    state_d = S_GAP;
                    next_d  = S_B2;
                    cnt_d   = GAP_LOAD;
                end
            end
            S_B2: begin
                oValid = 1'b1;
                oData  = {2'b00, px_q[5:0]};
                if (iTaken) begin
                    state_d = S_GAP;
                    next_d  = S_B3;
                    cnt_d   = GAP_LOAD;
                end
            end
            S_B3: begin
                oValid = 1'b1;
                oData  = {2'b00, py_q[5:0]};
                if (iTaken) begin
                    state_d = S_GAP;
                    next_d  = S_IDLE;
                    cnt_d   = GAP_LOAD;
                end
            end
            S_GAP: begin
                // Leave while the count steps 1->0 so the next byte shows BYTE_GAP cycles after the take.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = next_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (iIdent) begin
            state_d = S_IDENT;
            next_d  = S_IDLE;
            cnt_d   = '0;
            accx_d  = '0;
            accy_d  = '0;
            last_d  = '0;
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= S_IDLE;
            next_q  <= S_IDLE;
            cnt_q   <= '0;
            accx_q  <= '0;
            accy_q  <= '0;
            px_q    <= '0;
            py_q    <= '0;
            pl_q    <= 1'b0;
            pr_q    <= 1'b0;
            btn_q   <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            next_q  <= next_d;
            cnt_q   <= cnt_d;
            accx_q  <= accx_d;
            accy_q  <= accy_d;
            px_q    <= px_d;
            py_q    <= py_d;
            pl_q    <= pl_d;
            pr_q    <= pr_d;
            btn_q   <= {iBtnL, iBtnR};
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_serial_mouse_encoder.sv
// Scoreboard bench for serial_mouse_encoder: a transaction-level model predicts every byte
// and every cycle of oValid; a negedge monitor pops and compares on each handshake.
module tb_serial_mouse_encoder;
    localparam int G   = 12;
    localparam int AW  = 10;
    localparam int LIM = 1 << (AW - 1);

    logic              iClk;
    logic              iRstN;
    logic              iMove;
    logic signed [8:0] iDx;
    logic signed [8:0] iDy;
    logic              iBtnL;
    logic              iBtnR;
    logic              iIdent;
    logic [7:0]        oData;
    logic              oValid;
    logic              iTaken;

    serial_mouse_encoder #(.BYTE_GAP(G), .ACC_W(AW)) dut (
        .iClk   (iClk),
        .iRstN  (iRstN),
        .iMove  (iMove),
        .iDx    (iDx),
        .iDy    (iDy),
        .iBtnL  (iBtnL),
        .iBtnR  (iBtnR),
        .iIdent (iIdent),
        .oData  (oData),
        .oValid (oValid),
        .iTaken (iTaken)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int errors = 0;
    int checks = 0;
    int take_mode = 1;

    // Reference model state: motion totals, bytes still owed in the current transfer,
    // and cycles of silence remaining after a taken byte.
    int         m_ax = 0, m_ay = 0, m_left = 0, m_gap = 0;
    logic [1:0] m_btn = 2'b00, m_last = 2'b00;
    logic [7:0] exp_q[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors < 30) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int msat(input int v);
        if (v > LIM - 1) return LIM - 1;
        if (v < -LIM) return -LIM;
        return v;
    endfunction

    function automatic int mclamp(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    always @(posedge iClk or negedge iRstN) begin : model
        int dxm, dym, px, py, b1;
        if (!iRstN) begin
            m_ax = 0; m_ay = 0; m_left = 0; m_gap = 0;
            m_btn = 2'b00; m_last = 2'b00;
            exp_q.delete();
        end else begin
            if (iIdent) begin
                m_ax = 0; m_ay = 0; m_last = 2'b00;
                exp_q.delete();
                exp_q.push_back(8'h4D);
                m_left = 1; m_gap = 0;
            end else begin
                dxm = iMove ? int'(iDx) : 0;
                dym = iMove ? int'(iDy) : 0;
                px = 0; py = 0;
                if (m_left == 0 && m_gap == 0) begin
                    if (m_ax != 0 || m_ay != 0 || m_btn != m_last) begin
                        px = mclamp(m_ax);
                        py = mclamp(m_ay);
                        b1 = 64 + 32 * int'(m_btn[1]) + 16 * int'(m_btn[0])
                           + 4 * ((py & 255) / 64) + ((px & 255) / 64);
                        exp_q.push_back(8'(b1));
                        exp_q.push_back(8'(px & 63));
                        exp_q.push_back(8'(py & 63));
                        m_left = 3;
                        m_last = m_btn;
                    end
                end else if (m_gap > 0) begin
                    m_gap--;
                end else if (iTaken) begin
                    m_left--;
                    m_gap = G - 1;
                end
                m_ax = msat(m_ax - px + dxm);
                m_ay = msat(m_ay - py + dym);
            end
            m_btn = {iBtnL, iBtnR};
        end
    end

    always @(negedge iClk) begin : monitor
        bit ev;
        ev = (m_left > 0 && m_gap == 0);
        chk("valid", int'(oValid), int'(ev));
        if (ev) begin
            if (exp_q.size() == 0) begin
                chk("queue_nonempty", 0, 1);
            end else begin
                chk("data", int'(oData), int'(exp_q[0]));
                if (iTaken && !iIdent) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(posedge iClk);
            #1;
            case (take_mode)
                0:       iTaken = 1'b0;
                1:       iTaken = 1'b1;
                default: iTaken = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic tick();
        @(posedge iClk);
        #1;
        iMove  = 1'b0;
        iIdent = 1'b0;
    endtask

    task automatic do_move(input int dx, input int dy);
        iMove = 1'b1;
        iDx   = 9'(dx);
        iDy   = 9'(dy);
        tick();
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n;
        n = 0;
        tick();
        while (!(m_left == 0 && m_gap == 0 && m_ax == 0 && m_ay == 0 && m_btn == m_last) && n < budget) begin
            tick();
            n++;
        end
        chk({nm, "_timeout"}, int'(n >= budget), 0);
    endtask

    task automatic wait_present(input string nm, input int left, input int budget);
        int n;
        n = 0;
        while (!(m_left == left && m_gap == 0) && n < budget) begin
            tick();
            n++;
        end
        chk({nm, "_timeout"}, int'(n >= budget), 0);
    endtask

    task automatic wait_gap(input int budget);
        int n;
        n = 0;
        while (m_gap == 0 && n < budget) begin
            tick();
            n++;
        end
        chk("gap_timeout", int'(n >= budget), 0);
    endtask

    initial begin
        iRstN = 1'b0; iMove = 1'b0; iDx = '0; iDy = '0;
        iBtnL = 1'b0; iBtnR = 1'b0; iIdent = 1'b0; iTaken = 1'b0;
        repeat (3) @(posedge iClk);
        #1;
        chk("rst_valid", int'(oValid), 0);
        chk("rst_data", int'(oData), 0);
        iRstN = 1'b1;
        tick();

        take_mode = 1;
        do_move(5, -3);
        wait_idle("small_move", 300);

        do_move(300, 0);
        wait_idle("big_move", 600);

        do_move(20, 7);
        wait_present("reach_b2", 2, 200);
        iIdent = 1'b1;
        tick();
        chk("ident_byte", int'(oData), 8'h4D);
        chk("ident_valid", int'(oValid), 1);
        wait_idle("ident", 200);
        repeat (30) tick();

        iBtnL = 1'b1;
        wait_idle("btn_press", 200);
        iBtnL = 1'b0;
        wait_idle("btn_release", 200);

        take_mode = 0;
        do_move(1, 1);
        wait_present("reach_b1", 3, 50);
        repeat (10) tick();
        do_move(2, 0);
        repeat (990) tick();
        take_mode = 1;
        wait_idle("hold", 400);

        do_move(3, 3);
        wait_gap(100);
        #2;
        iRstN = 1'b0;
        #1;
        chk("midrst_valid", int'(oValid), 0);
        chk("midrst_data", int'(oData), 0);
        repeat (2) @(posedge iClk);
        #1;
        iRstN = 1'b1;
        repeat (60) tick();

        take_mode = 2;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                iMove = 1'b1;
                iDx   = 9'($urandom_range(0, 511));
                iDy   = 9'($urandom_range(0, 511));
            end
            if ($urandom_range(0, 39) == 0) iBtnL = ~iBtnL;
            if ($urandom_range(0, 39) == 0) iBtnR = ~iBtnR;
            if ($urandom_range(0, 399) == 0) iIdent = 1'b1;
            tick();
        end
        take_mode = 1;
        wait_idle("drain", 3000);
        chk("queue_empty_end", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
